// File: rtl/ray_scan_scheduler_pkg.sv
// Shared constants for the ray scan scheduler: colours, FSM encodings and ray
// direction field layout.
package ray_scan_scheduler_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StIssue = 3'd1;
   localparam state_t StWait  = 3'd2;
   localparam state_t StWrite = 3'd3;
   localparam state_t StDone  = 3'd4;

   localparam logic [11:0] BLACK = 12'h000;
   localparam logic [11:0] WHITE = 12'hFFF;

   localparam int unsigned DIR_X_LSB = 18;
   localparam int unsigned DIR_Y_LSB = 8;
   localparam int unsigned DIR_Z_LSB = 0;

   function automatic logic [27:0] pack_dir(logic [9:0] x, logic [9:0] y, logic [7:0] z);
      logic [27:0] d;
      d = '0;
      d[DIR_X_LSB +: 10] = x;
      d[DIR_Y_LSB +: 10] = y;
      d[DIR_Z_LSB +: 8]  = z;
      return d;
   endfunction

endpackage

// File: rtl/ray_scan_scheduler_if.sv
// Tracer and framebuffer connection of the ray scan scheduler.
// master = scheduler side, slave = tracer/framebuffer side.
interface ray_scan_scheduler_if;
   logic [27:0] ray_init;
   logic [27:0] ray_dir;
   logic        ray_valid;
   logic        tracer_ret;
   logic [11:0] tracer_color;
   logic        collision_sig;
   logic        fb_we;
   logic [19:0] fb_addr;
   logic [11:0] fb_data;

   modport master (
      output ray_init, ray_dir, ray_valid, fb_we, fb_addr, fb_data,
      input  tracer_ret, tracer_color, collision_sig
   );

   modport slave (
      input  ray_init, ray_dir, ray_valid, fb_we, fb_addr, fb_data,
      output tracer_ret, tracer_color, collision_sig
   );
endinterface

// File: rtl/ray_scan_scheduler_raster_counter.sv
// Raster-order pixel walker: x/y position plus a running linear address,
// reusable by any scan engine that steps one pixel at a time.
module ray_scan_scheduler_raster_counter #(
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        advance_i,
   output logic [9:0]  x_o,
   output logic [9:0]  y_o,
   output logic [19:0] addr_o,
   output logic        last_o
);

   localparam logic [9:0] XMax = 10'(H_RES - 1);
   localparam logic [9:0] YMax = 10'(V_RES - 1);

   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [19:0] addr_q, addr_d;
   logic        last;

   assign last = (x_q == XMax) && (y_q == YMax);

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
      if (clear_i || (advance_i && last)) begin
         x_d    = '0;
         y_d    = '0;
         addr_d = '0;
      end else if (advance_i) begin
         addr_d = addr_q + 20'd1;
         if (x_q == XMax) begin
            x_d = '0;
            y_d = y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         addr_q <= addr_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign addr_o = addr_q;
   assign last_o = last;

endmodule

// File: rtl/ray_scan_scheduler.sv
// Frame sequencer: walks pixels in raster order, issues one ray per pixel to
// the tracer, waits for its result or a timeout and writes the colour out.
module ray_scan_scheduler
   import ray_scan_scheduler_pkg::*;
#(
   parameter int unsigned H_RES   = 640,
   parameter int unsigned V_RES   = 480,
   parameter logic [7:0]  FOCAL   = 8'd128,
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start_i,
   input  logic [27:0]           cam_pos_i,
   ray_scan_scheduler_if.master  ray_if,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic [15:0]           timeout_cnt_o,
   output logic [15:0]           collide_cnt_o
);

   localparam logic [10:0] SettleW  = 11'(SETTLE);
   localparam logic [10:0] TimeoutW = 11'(TIMEOUT);

   state_t      state_q, state_d;
   logic [27:0] ray_init_q, ray_init_d;
   logic [27:0] ray_dir_q, ray_dir_d;
   logic [11:0] fb_data_q, fb_data_d;
   logic [10:0] wait_cnt_q, wait_cnt_d;
   logic [15:0] timeout_cnt_q, timeout_cnt_d;
   logic [15:0] collide_cnt_q, collide_cnt_d;

   logic [10:0] wait_inc;
   logic        ret_ok;
   logic        timed_out;
   logic        start;
   logic [9:0]  pix_x, pix_y;
   logic [19:0] pix_addr;
   logic        pix_last;

   assign start     = (state_q == StIdle) && frame_start_i;
   // wait_inc is the count including the current WAIT cycle.
   assign wait_inc  = wait_cnt_q + 11'd1;
   assign ret_ok    = ray_if.tracer_ret && (wait_inc >= SettleW);
   assign timed_out = (wait_inc == TimeoutW);

   ray_scan_scheduler_raster_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_raster (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (start),
      .advance_i (state_q == StWrite),
      .x_o       (pix_x),
      .y_o       (pix_y),
      .addr_o    (pix_addr),
      .last_o    (pix_last)
   );

   always_comb begin
      state_d       = state_q;
      ray_init_d    = ray_init_q;
      ray_dir_d     = ray_dir_q;
      fb_data_d     = fb_data_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      collide_cnt_d = collide_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (frame_start_i) begin
               ray_init_d    = cam_pos_i;
               timeout_cnt_d = '0;
               collide_cnt_d = '0;
               state_d       = StIssue;
            end
         end
         StIssue: begin
            ray_dir_d  = pack_dir(pix_x, pix_y, FOCAL);
            wait_cnt_d = '0;
            state_d    = StWait;
         end
         StWait: begin
            wait_cnt_d = wait_inc;
            // A valid return beats a timeout reached in the same cycle.
            if (ret_ok) begin
               fb_data_d = ray_if.tracer_color;
               if (ray_if.collision_sig && (collide_cnt_q != 16'hFFFF)) begin
                  collide_cnt_d = collide_cnt_q + 16'd1;
               end
               state_d = StWrite;
            end else if (timed_out) begin
               fb_data_d = BLACK;
               if (timeout_cnt_q != 16'hFFFF) begin
                  timeout_cnt_d = timeout_cnt_q + 16'd1;
               end
               state_d = StWrite;
            end
         end
         StWrite: state_d = pix_last ? StDone : StIssue;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         ray_init_q    <= '0;
         ray_dir_q     <= '0;
         fb_data_q     <= '0;
         wait_cnt_q    <= '0;
         timeout_cnt_q <= '0;
         collide_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         ray_init_q    <= ray_init_d;
         ray_dir_q     <= ray_dir_d;
         fb_data_q     <= fb_data_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         collide_cnt_q <= collide_cnt_d;
      end
   end

   assign ray_if.ray_init  = ray_init_q;
   assign ray_if.ray_dir   = ray_dir_q;
   assign ray_if.ray_valid = (state_q == StWait);
   assign ray_if.fb_we     = (state_q == StWrite);
   assign ray_if.fb_addr   = pix_addr;
   assign ray_if.fb_data   = fb_data_q;

   assign busy_o        = (state_q == StIssue) || (state_q == StWait) || (state_q == StWrite);
   assign frame_done_o  = (state_q == StDone);
   assign timeout_cnt_o = timeout_cnt_q;
   assign collide_cnt_o = collide_cnt_q;

endmodule

// File: doc/ray_scan_scheduler.md
Name: ray_scan_scheduler

Overview:
- Sequences the per-pixel ray tracer datapath across a full frame.
- On a frame start it latches the camera origin and walks pixels in raster order. For each pixel it builds the ray direction, presents the ray to the tracer, and waits for the tracer's return or a timeout.
- It then writes the 12-bit colour to the framebuffer write port.
- Sits between the frame/display control logic and the tracer and framebuffer RAM.

Parameters:
- H_RES, 640, pixels per line (1..1023)
- V_RES, 480, lines per frame (1..1023)
- FOCAL, 8'd128, constant z component of every ray direction
- SETTLE, 2, minimum cycles the ray is held before tracer_ret is sampled (>=1)
- TIMEOUT, 255, max cycles in WAIT before forcing BLACK (>SETTLE, <=1023)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle request to render a frame; ignored unless idle
- cam_pos  in  28  camera origin, latched on accepted frame_start
- ray_init  out  28  ray origin to tracer
- ray_dir  out  28  ray direction {x[9:0], y[9:0], FOCAL[7:0]}
- ray_valid  out  1  high while the ray on ray_init/ray_dir is being traced
- tracer_ret  in  1  tracer result valid (level)
- tracer_color  in  12  tracer colour output
- collision_sig  in  1  tracer collision flag
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  20  y*H_RES + x
- fb_data  out  12  pixel colour
- busy  out  1  high from accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel is written
- timeout_cnt  out  16  per-frame count of timed-out pixels, saturating
- collide_cnt  out  16  per-frame count of pixels with collision_sig, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; every register clears on the rising clk edge while rst=1, including mid-frame. No framebuffer write completes in the reset cycle.
- Reset values: all outputs 0; state IDLE; x=y=0.
- State IDLE:
  - frame_start=1 -> latch cam_pos into ray_init; x=0, y=0; clear both counters; busy=1; go to ISSUE.
  - frame_start while busy is ignored (not queued).
- State ISSUE (1 cycle): drive ray_dir from x/y; clear wait_cnt; ray_valid=1 from the next cycle; go to WAIT.
- State WAIT: ray_valid=1; ray_dir and ray_init stable; wait_cnt increments each cycle. Exits are checked in this priority order:
  - wait_cnt>=SETTLE and tracer_ret=1 -> capture tracer_color into fb_data; if collision_sig=1, collide_cnt +1 (saturate at 16'hFFFF); go to WRITE.
  - wait_cnt==TIMEOUT -> fb_data=12'h000; timeout_cnt +1 (saturate); go to WRITE.
  - tracer_ret=1 on the same cycle the timeout is reached -> the tracer result wins.
  - tracer_ret=1 before SETTLE -> ignored (stale result from the previous ray).
- State WRITE (1 cycle): fb_we=1; fb_addr=y*H_RES+x; ray_valid=0. Then advance:
  - x<H_RES-1 -> x+1.
  - otherwise x=0; if y<V_RES-1 -> y+1.
  - otherwise go to DONE.
  - In all non-final cases go back to ISSUE.
- State DONE (1 cycle): frame_done=1; busy=0; return to IDLE. Counters hold their values until the next accepted frame_start.
- Address arithmetic: fb_addr is kept as a running register (+1 per write, 0 at frame start), not a multiplier. It must equal y*H_RES+x; the last address is H_RES*V_RES-1.
- Latency per pixel: 1 (ISSUE) + max(SETTLE, return) wait cycles + 1 (WRITE). With the tracer returning immediately, that is SETTLE+2 cycles per pixel.

Decomposition:
- Shared package/header (alongside the scene RAM header):
  - colour constants BLACK=12'h000, WHITE=12'hFFF
  - state encodings IDLE/ISSUE/WAIT/WRITE/DONE
  - direction field offsets
- One natural sub-module: raster_counter. It holds x/y/addr, takes an advance input, and outputs a last-pixel flag, so it can be reused by the display scan-out.

Test Plan:
- Reset mid-WAIT: rst for 1 cycle in WAIT -> next cycle all outputs 0, state IDLE, no fb_we.
- H_RES=4, V_RES=2, SETTLE=2, tracer_ret tied 1 with colour 12'hFFF -> exactly 8 writes:
  - addresses 0..7, data FFF, each 4 cycles apart
  - frame_done 1 cycle after the last write
  - ray_dir for pixel 5 = {10'd1, 10'd1, 8'd128}
- Tracer never returns, TIMEOUT=10, 2x1 frame -> 2 writes of 12'h000 at wait_cnt=10; timeout_cnt=2.
- tracer_ret pulsed at wait_cnt=1 only (SETTLE=2) -> ignored; the pixel times out and writes BLACK.
- collision_sig=1 on 3 of 8 returned pixels -> collide_cnt=3. A second frame_start clears it to 0 before counting again.
- frame_start asserted during busy and on the same cycle as a frame_done pulse -> both ignored; a later frame_start in IDLE is accepted with the new cam_pos on ray_init.
